// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data ports,
// with data-side MMIO decode for signature output and simulation halt.
module mem_arbiter #(
    parameter int MEM_ADDR_WIDTH = 22,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                      sysclk,
    input  logic                      rst_in,
    input  logic                      i_req,
    input  logic [31:0]               i_addr,
    output logic                      i_gnt,
    output logic                      i_rvalid,
    output logic [31:0]               i_rdata,
    input  logic                      d_req,
    input  logic                      d_we,
    input  logic [31:0]               d_addr,
    input  logic [31:0]               d_wdata,
    output logic                      d_gnt,
    output logic                      d_rvalid,
    output logic [31:0]               d_rdata,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]               mem_wdata,
    input  logic [31:0]               mem_rdata,
    output logic                      sig_valid,
    output logic [31:0]               sig_data,
    output logic                      halt
);

    localparam logic [3:0]  LP_LIMIT     = 4'(STARVE_LIMIT);
    localparam logic [31:0] LP_SIG_ADDR  = 32'hF000_0004;
    localparam logic [31:0] LP_HALT_ADDR = 32'hCAFE_CAFE;
    localparam logic [31:0] LP_HALT_CMD  = 32'hF000_0000;

    logic [3:0]  r_starve_cnt;
    logic        r_tag_valid;
    logic        r_tag_port;   // 1 = data port owns the returning read
    logic        r_tag_zero;   // return 0 instead of mem_rdata
    logic        r_sig_valid;
    logic [31:0] r_sig_data;
    logic        r_halt;

    logic        w_open;
    logic        w_i_gnt;
    logic        w_d_gnt;
    logic        w_d_mem;
    logic        w_d_sig;
    logic        w_d_halt;
    logic        w_unused_bits;

    // Fetch bits outside the word index are deliberately ignored.
    assign w_unused_bits = ^{i_addr[31:MEM_ADDR_WIDTH+2], i_addr[1:0]};

    always_comb begin
        w_open   = !r_halt && !rst_in;
        w_i_gnt  = w_open && i_req && (!d_req || (r_starve_cnt >= LP_LIMIT));
        w_d_gnt  = w_open && d_req && !w_i_gnt;
        w_d_mem  = (d_addr[31:28] == 4'h0);
        w_d_sig  = d_we && (d_addr == LP_SIG_ADDR);
        w_d_halt = d_we && (d_addr == LP_HALT_ADDR) && (d_wdata == LP_HALT_CMD);
    end

    always_comb begin
        mem_en    = w_i_gnt || (w_d_gnt && w_d_mem);
        mem_we    = w_d_gnt && w_d_mem && d_we;
        mem_wdata = mem_we ? d_wdata : 32'h0;
        mem_addr  = '0;
        if (w_i_gnt) begin
            mem_addr = i_addr[MEM_ADDR_WIDTH+1:2];
        end else if (w_d_gnt && w_d_mem) begin
            mem_addr = d_addr[MEM_ADDR_WIDTH+1:2];
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst_in) begin
            r_starve_cnt <= 4'h0;
            r_tag_valid  <= 1'b0;
            r_tag_port   <= 1'b0;
            r_tag_zero   <= 1'b0;
            r_sig_valid  <= 1'b0;
            r_sig_data   <= 32'h0;
            r_halt       <= 1'b0;
        end else begin
            if (!i_req || w_i_gnt) begin
                r_starve_cnt <= 4'h0;
            end else if (r_starve_cnt != 4'hF) begin
                r_starve_cnt <= r_starve_cnt + 4'h1;
            end
            r_tag_valid <= w_i_gnt || (w_d_gnt && !d_we);
            r_tag_port  <= w_d_gnt;
            r_tag_zero  <= w_d_gnt && !w_d_mem;
            r_sig_valid <= w_d_gnt && w_d_sig;
            if (w_d_gnt && w_d_sig) begin
                r_sig_data <= d_wdata;
            end
            if (w_d_gnt && w_d_halt) begin
                r_halt <= 1'b1;
            end
        end
    end

    // Returns are masked while reset is asserted so a read granted just
    // before reset never surfaces.
    always_comb begin
        i_rvalid = r_tag_valid && !r_tag_port && !rst_in;
        d_rvalid = r_tag_valid && r_tag_port && !rst_in;
        i_rdata  = i_rvalid ? mem_rdata : 32'h0;
        d_rdata  = (d_rvalid && !r_tag_zero) ? mem_rdata : 32'h0;
    end

    assign i_gnt     = w_i_gnt;
    assign d_gnt     = w_d_gnt;
    assign sig_valid = r_sig_valid;
    assign sig_data  = r_sig_data;
    assign halt      = r_halt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus randomized traffic
// checked against a rule-level reference model and a behavioural memory.
module tb_mem_arbiter;

    localparam int AW  = 12;
    localparam int LIM = 4;

    logic          sysclk;
    logic          rst_in;
    logic          i_req;
    logic [31:0]   i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic [31:0]   i_rdata;
    logic          d_req;
    logic          d_we;
    logic [31:0]   d_addr;
    logic [31:0]   d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [31:0]   d_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          sig_valid;
    logic [31:0]   sig_data;
    logic          halt;

    int checks;
    int failures;

    mem_arbiter #(.MEM_ADDR_WIDTH(AW), .STARVE_LIMIT(LIM)) dut (
        .sysclk(sysclk), .rst_in(rst_in),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .sig_valid(sig_valid), .sig_data(sig_data), .halt(halt)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // Behavioural single-port memory with one-cycle registered read.
    logic [31:0] emu_mem [0:(1<<AW)-1];
    always @(posedge sysclk) begin
        if (mem_en) begin
            if (mem_we) emu_mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= emu_mem[mem_addr];
        end
    end

    // Reference model state.
    logic [31:0] ref_mem [int];
    int          s_model;
    bit          exp_i_rv, exp_d_rv, exp_sig_v, exp_halt;
    logic [31:0] exp_i_rd, exp_d_rd, exp_sig_d;

    function automatic logic [31:0] ref_rd(input int idx);
        if (ref_mem.exists(idx)) return ref_mem[idx];
        return 32'h0;
    endfunction

    function automatic bit fetch_wins();
        return i_req && !exp_halt && (!d_req || s_model >= LIM);
    endfunction

    function automatic bit data_wins();
        return d_req && !exp_halt && !fetch_wins();
    endfunction

    task automatic model_clear();
        s_model = 0; exp_i_rv = 0; exp_d_rv = 0; exp_sig_v = 0;
        exp_sig_d = 32'h0; exp_halt = 0;
    endtask

    // Applies the effects of this cycle's expected grants to the model.
    task automatic model_advance(input bit ig, input bit dg);
        exp_i_rv = 0; exp_d_rv = 0; exp_sig_v = 0;
        if (ig) begin
            exp_i_rv = 1;
            exp_i_rd = ref_rd(int'(i_addr[AW+1:2]));
        end
        if (dg) begin
            if (d_addr[31:28] == 4'h0) begin
                if (d_we) ref_mem[int'(d_addr[AW+1:2])] = d_wdata;
                else begin exp_d_rv = 1; exp_d_rd = ref_rd(int'(d_addr[AW+1:2])); end
            end else if (d_we) begin
                if (d_addr == 32'hF0000004) begin exp_sig_v = 1; exp_sig_d = d_wdata; end
                else if (d_addr == 32'hCAFECAFE && d_wdata == 32'hF0000000) exp_halt = 1;
            end else begin
                exp_d_rv = 1; exp_d_rd = 32'h0;
            end
        end
        if (!i_req || ig) s_model = 0;
        else if (s_model < 15) s_model++;
    endtask

    task automatic do_reset();
        rst_in = 1; i_req = 0; d_req = 0; d_we = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0;
        @(negedge sysclk);
        @(negedge sysclk);
        rst_in = 0;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (i_rvalid !== 1'b0) begin failures++; $display("FAIL reset_i_rvalid got=%b exp=0", i_rvalid); end
        checks++; if (d_rvalid !== 1'b0) begin failures++; $display("FAIL reset_d_rvalid got=%b exp=0", d_rvalid); end
        checks++; if (sig_valid !== 1'b0) begin failures++; $display("FAIL reset_sig_valid got=%b exp=0", sig_valid); end
        checks++; if (sig_data !== 32'h0) begin failures++; $display("FAIL reset_sig_data got=%h exp=0", sig_data); end
        checks++; if (halt !== 1'b0) begin failures++; $display("FAIL reset_halt got=%b exp=0", halt); end
        checks++; if ({i_gnt, d_gnt, mem_en, mem_we} !== 4'b0) begin failures++; $display("FAIL reset_idle got=%b exp=0000", {i_gnt, d_gnt, mem_en, mem_we}); end
        checks++; if (mem_addr !== '0 || mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_mem_bus addr=%h wdata=%h exp=0", mem_addr, mem_wdata); end
        model_advance(0, 0);
        @(negedge sysclk);
    endtask

    // Seeds words 0..64 through the data port so every location read later is known.
    task automatic init_mem();
        for (int k = 0; k <= 64; k++) begin
            d_req = 1; d_we = 1; d_addr = 32'(k) << 2; d_wdata = 32'hA5000000 | 32'(k * 7);
            #1;
            model_advance(0, data_wins());
            @(negedge sysclk);
        end
        d_req = 0; d_we = 0;
    endtask

    task automatic test_fetch_only();
        d_req = 1; d_we = 1; d_addr = 32'h4; d_wdata = 32'h00000013;
        #1;
        model_advance(0, data_wins());
        @(negedge sysclk);
        d_req = 0; d_we = 0; i_req = 1; i_addr = 32'h4;
        #1;
        checks++; if (i_gnt !== 1'b1 || d_gnt !== 1'b0) begin failures++; $display("FAIL fetch_gnt i_gnt=%b d_gnt=%b exp=1/0", i_gnt, d_gnt); end
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0) begin failures++; $display("FAIL fetch_mem_en en=%b we=%b exp=1/0", mem_en, mem_we); end
        checks++; if (mem_addr !== AW'(1)) begin failures++; $display("FAIL fetch_mem_addr got=%h exp=1", mem_addr); end
        model_advance(1, 0);
        $display("txn fetch addr=%h", i_addr);
        @(negedge sysclk);
        i_req = 0;
        #1;
        checks++; if (i_rvalid !== 1'b1 || i_rdata !== 32'h00000013) begin failures++; $display("FAIL fetch_rdata rvalid=%b data=%h exp=1/00000013", i_rvalid, i_rdata); end
        checks++; if (d_rvalid !== 1'b0) begin failures++; $display("FAIL fetch_no_d_rvalid got=%b exp=0", d_rvalid); end
        model_advance(0, 0);
        @(negedge sysclk);
        #1;
        checks++; if (i_rvalid !== 1'b0) begin failures++; $display("FAIL fetch_rvalid_single got=%b exp=0", i_rvalid); end
        @(negedge sysclk);
    endtask

    task automatic test_write_read();
        d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'hDEADBEEF;
        #1;
        checks++; if (d_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== AW'(8) || mem_wdata !== 32'hDEADBEEF) begin
            failures++; $display("FAIL wr_bus gnt=%b we=%b addr=%h wdata=%h exp=1/1/8/deadbeef", d_gnt, mem_we, mem_addr, mem_wdata); end
        model_advance(0, 1);
        $display("txn dwrite addr=%h data=%h", d_addr, d_wdata);
        @(negedge sysclk);
        d_req = 0; d_we = 0;
        #1;
        checks++; if (d_rvalid !== 1'b0) begin failures++; $display("FAIL wr_no_rvalid got=%b exp=0", d_rvalid); end
        model_advance(0, 0);
        @(negedge sysclk);
        d_req = 1; d_we = 0; d_addr = 32'h20;
        #1;
        checks++; if (d_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0) begin failures++; $display("FAIL rd_gnt gnt=%b en=%b we=%b exp=1/1/0", d_gnt, mem_en, mem_we); end
        model_advance(0, 1);
        $display("txn dread addr=%h", d_addr);
        @(negedge sysclk);
        d_req = 0;
        #1;
        checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data rvalid=%b data=%h exp=1/deadbeef", d_rvalid, d_rdata); end
        model_advance(0, 0);
        @(negedge sysclk);
    endtask

    task automatic test_signature();
        d_req = 1; d_we = 1; d_addr = 32'hF0000004; d_wdata = 32'h12345678;
        #1;
        checks++; if (d_gnt !== 1'b1 || mem_en !== 1'b0) begin failures++; $display("FAIL sig_gnt gnt=%b mem_en=%b exp=1/0", d_gnt, mem_en); end
        checks++; if (sig_valid !== 1'b0) begin failures++; $display("FAIL sig_early got=%b exp=0", sig_valid); end
        model_advance(0, 1);
        $display("txn sigwrite data=%h", d_wdata);
        @(negedge sysclk);
        d_we = 0;
        #1;
        checks++; if (sig_valid !== 1'b1 || sig_data !== 32'h12345678) begin failures++; $display("FAIL sig_pulse valid=%b data=%h exp=1/12345678", sig_valid, sig_data); end
        checks++; if (d_gnt !== 1'b1 || mem_en !== 1'b0) begin failures++; $display("FAIL sig_rd_gnt gnt=%b mem_en=%b exp=1/0", d_gnt, mem_en); end
        model_advance(0, 1);
        @(negedge sysclk);
        d_req = 0;
        #1;
        checks++; if (sig_valid !== 1'b0) begin failures++; $display("FAIL sig_one_cycle got=%b exp=0", sig_valid); end
        checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h0) begin failures++; $display("FAIL sig_rd_zero rvalid=%b data=%h exp=1/0", d_rvalid, d_rdata); end
        model_advance(0, 0);
        @(negedge sysclk);
    endtask

    task automatic test_contention();
        int n_fetch;
        bit prev_i, prev_d;
        do_reset();
        n_fetch = 0; prev_i = 0; prev_d = 0;
        i_req = 1; i_addr = 32'h8; d_req = 1; d_we = 0; d_addr = 32'h100;
        for (int c = 0; c < 15; c++) begin
            #1;
            checks++; if (i_gnt !== (c % 5 == 4) || d_gnt !== (c % 5 != 4)) begin
                failures++; $display("FAIL contend_gnt cycle=%0d i_gnt=%b d_gnt=%b exp_i=%b", c, i_gnt, d_gnt, c % 5 == 4); end
            checks++; if (i_rvalid !== prev_i || d_rvalid !== prev_d) begin
                failures++; $display("FAIL contend_rvalid cycle=%0d i=%b d=%b exp=%b/%b", c, i_rvalid, d_rvalid, prev_i, prev_d); end
            if (prev_d) begin
                checks++; if (d_rdata !== exp_d_rd) begin failures++; $display("FAIL contend_d_rdata cycle=%0d got=%h exp=%h", c, d_rdata, exp_d_rd); end
            end
            if (prev_i) begin
                checks++; if (i_rdata !== exp_i_rd) begin failures++; $display("FAIL contend_i_rdata cycle=%0d got=%h exp=%h", c, i_rdata, exp_i_rd); end
            end
            if (i_gnt) n_fetch++;
            prev_i = (c % 5 == 4); prev_d = (c % 5 != 4);
            model_advance(prev_i, prev_d);
            $display("txn contend cycle=%0d winner=%s", c, prev_i ? "fetch" : "data");
            @(negedge sysclk);
        end
        i_req = 0; d_req = 0;
        checks++; if (n_fetch != 3) begin failures++; $display("FAIL contend_fetch_count got=%0d exp=3", n_fetch); end
        model_advance(0, 0);
        @(negedge sysclk);
    endtask

    task automatic test_random();
        bit ip, dp, ei, ed;
        int idx, kind;
        logic [AW-1:0] ea;
        ip = 0; dp = 0;
        for (int c = 0; c < 400; c++) begin
            if (!ip && $urandom_range(0, 1) == 1) begin
                ip = 1; idx = $urandom_range(0, 31);
                i_addr = ($urandom & 32'hFFFFC003) | (32'(idx) << 2);
            end
            if (!dp && $urandom_range(0, 2) != 0) begin
                dp = 1; kind = $urandom_range(0, 9); d_we = $urandom_range(0, 1) == 1;
                d_wdata = $urandom; idx = $urandom_range(0, 31);
                if (kind <= 5)      d_addr = ($urandom & 32'h0FFFC000) | (32'(idx) << 2);
                else if (kind <= 7) d_addr = 32'hF0000004;
                else if (kind == 8) d_addr = 32'h80000010;
                else begin d_addr = 32'hCAFECAFE; d_wdata = d_wdata | 32'h1; end
            end
            i_req = ip; d_req = dp;
            #1;
            ei = fetch_wins(); ed = data_wins();
            ea = ei ? i_addr[AW+1:2] : ((ed && d_addr[31:28] == 4'h0) ? d_addr[AW+1:2] : '0);
            checks++; if (i_gnt !== ei || d_gnt !== ed) begin failures++; $display("FAIL rnd_gnt cycle=%0d i=%b d=%b exp=%b/%b", c, i_gnt, d_gnt, ei, ed); end
            checks++; if (mem_en !== (ei || (ed && d_addr[31:28] == 4'h0)) || mem_addr !== ea) begin
                failures++; $display("FAIL rnd_mem_port cycle=%0d en=%b addr=%h exp_addr=%h", c, mem_en, mem_addr, ea); end
            checks++; if (mem_we !== (ed && d_we && d_addr[31:28] == 4'h0)) begin failures++; $display("FAIL rnd_mem_we cycle=%0d got=%b", c, mem_we); end
            if (mem_we === 1'b1) begin
                checks++; if (mem_wdata !== d_wdata) begin failures++; $display("FAIL rnd_mem_wdata cycle=%0d got=%h exp=%h", c, mem_wdata, d_wdata); end
            end
            checks++; if (i_rvalid !== exp_i_rv || d_rvalid !== exp_d_rv) begin
                failures++; $display("FAIL rnd_rvalid cycle=%0d i=%b d=%b exp=%b/%b", c, i_rvalid, d_rvalid, exp_i_rv, exp_d_rv); end
            if (exp_i_rv) begin
                checks++; if (i_rdata !== exp_i_rd) begin failures++; $display("FAIL rnd_i_rdata cycle=%0d got=%h exp=%h", c, i_rdata, exp_i_rd); end
            end
            if (exp_d_rv) begin
                checks++; if (d_rdata !== exp_d_rd) begin failures++; $display("FAIL rnd_d_rdata cycle=%0d got=%h exp=%h", c, d_rdata, exp_d_rd); end
            end
            checks++; if (sig_valid !== exp_sig_v || sig_data !== exp_sig_d) begin
                failures++; $display("FAIL rnd_sig cycle=%0d valid=%b data=%h exp=%b/%h", c, sig_valid, sig_data, exp_sig_v, exp_sig_d); end
            checks++; if (halt !== 1'b0) begin failures++; $display("FAIL rnd_halt cycle=%0d got=%b exp=0", c, halt); end
            if (ei) $display("txn rnd cycle=%0d fetch addr=%h", c, i_addr);
            if (ed) $display("txn rnd cycle=%0d data %s addr=%h wdata=%h", c, d_we ? "wr" : "rd", d_addr, d_wdata);
            model_advance(ei, ed);
            if (ei) ip = 0;
            if (ed) dp = 0;
            @(negedge sysclk);
        end
        i_req = 0; d_req = 0;
        model_advance(0, 0);
        @(negedge sysclk);
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        i_req = 1; i_addr = 32'h4;
        #1;
        checks++; if (i_gnt !== 1'b1) begin failures++; $display("FAIL midrst_gnt got=%b exp=1", i_gnt); end
        @(negedge sysclk);
        rst_in = 1; i_req = 0;
        #1;
        checks++; if (i_rvalid !== 1'b0) begin failures++; $display("FAIL midrst_rvalid got=%b exp=0", i_rvalid); end
        @(negedge sysclk);
        rst_in = 0; model_clear();
        #1;
        checks++; if (i_rvalid !== 1'b0) begin failures++; $display("FAIL midrst_after got=%b exp=0", i_rvalid); end
        // Build up starvation, then reset with both ports still requesting.
        i_req = 1; d_req = 1; d_we = 0; d_addr = 32'h100;
        @(negedge sysclk);
        @(negedge sysclk);
        @(negedge sysclk);
        rst_in = 1;
        #1;
        checks++; if (d_rvalid !== 1'b0 || i_gnt !== 1'b0 || d_gnt !== 1'b0) begin
            failures++; $display("FAIL midrst_quiet d_rvalid=%b i_gnt=%b d_gnt=%b exp=0", d_rvalid, i_gnt, d_gnt); end
        @(negedge sysclk);
        rst_in = 0; model_clear();
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (i_gnt !== (c == 4) || d_gnt !== (c != 4)) begin
                failures++; $display("FAIL midrst_starve cycle=%0d i_gnt=%b d_gnt=%b exp_i=%b", c, i_gnt, d_gnt, c == 4); end
            model_advance(c == 4, c != 4);
            @(negedge sysclk);
        end
        i_req = 0; d_req = 0;
        model_advance(0, 0);
        @(negedge sysclk);
    endtask

    task automatic test_halt();
        do_reset();
        d_req = 1; d_we = 1; d_addr = 32'hCAFECAFE; d_wdata = 32'h1;
        #1;
        checks++; if (d_gnt !== 1'b1 || mem_en !== 1'b0) begin failures++; $display("FAIL halt_bad_gnt gnt=%b en=%b exp=1/0", d_gnt, mem_en); end
        model_advance(0, 1);
        @(negedge sysclk);
        d_wdata = 32'hF0000000;
        #1;
        checks++; if (halt !== 1'b0) begin failures++; $display("FAIL halt_bad_cmd got=%b exp=0", halt); end
        checks++; if (d_gnt !== 1'b1) begin failures++; $display("FAIL halt_gnt got=%b exp=1", d_gnt); end
        model_advance(0, 1);
        $display("txn haltwrite data=%h", d_wdata);
        @(negedge sysclk);
        i_req = 1; i_addr = 32'h0; d_we = 0; d_addr = 32'h10;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (halt !== 1'b1) begin failures++; $display("FAIL halt_set cycle=%0d got=%b exp=1", c, halt); end
            checks++; if (i_gnt !== 1'b0 || d_gnt !== 1'b0 || mem_en !== 1'b0) begin
                failures++; $display("FAIL halt_block cycle=%0d i=%b d=%b en=%b exp=0", c, i_gnt, d_gnt, mem_en); end
            @(negedge sysclk);
        end
        do_reset();
        #1;
        checks++; if (halt !== 1'b0) begin failures++; $display("FAIL halt_cleared got=%b exp=0", halt); end
        i_req = 1;
        #1;
        checks++; if (i_gnt !== 1'b1) begin failures++; $display("FAIL halt_resume got=%b exp=1", i_gnt); end
        @(negedge sysclk);
        i_req = 0;
        @(negedge sysclk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        checks = 0; failures = 0;
        test_reset();
        init_mem();
        test_fetch_only();
        test_write_read();
        test_signature();
        test_contention();
        test_random();
        test_reset_mid_read();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
